// File: rtl/regfile_pkg.sv
// Shared types and constants for the pipelined register file.
package regfile_pkg;

  localparam int unsigned REG_AW   = 5;
  localparam int unsigned REG_DW   = 32;
  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REG_A0   = 10;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [REG_DW-1:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on write.
// A same-cycle issue and write to one index leaves the bit set (the new producer wins).
// Macro REGFILE_BYPASS_EN: a read port hit by the current write reports not-busy
// unless the same index is also being issued this cycle.
// Ports:
//   clk, rst        clock, async active-high reset
//   issue_valid_i   decode issued an instruction writing issue_rd_i
//   issue_rd_i      destination index of the issued instruction
//   we_i, wa_i      write-port enable and address
//   ad_i            packed read addresses, NUM_READ x ADDRESS_WIDTH
//   busy_c          per-read-port pending flag (combinational)
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = REG_AW,
  parameter int unsigned NUM_READ      = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              issue_valid_i,
  input  logic [ADDRESS_WIDTH-1:0]          issue_rd_i,
  input  logic                              we_i,
  input  logic [ADDRESS_WIDTH-1:0]          wa_i,
  input  logic [NUM_READ*ADDRESS_WIDTH-1:0] ad_i,
  output logic [NUM_READ-1:0]               busy_c
);

  localparam int unsigned DEPTH = 2 ** ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] ZERO_ADDR = ADDRESS_WIDTH'(REG_ZERO);

  logic [DEPTH-1:0]         pending_q;
  logic [DEPTH-1:0]         pending_d;
  logic [ADDRESS_WIDTH-1:0] lookup_addr;

  // Clear on write first, then set on issue so a concurrent issue wins.
  always_comb begin
    pending_d = pending_q;
    if (we_i && (wa_i != ZERO_ADDR)) pending_d[wa_i] = 1'b0;
    if (issue_valid_i && (issue_rd_i != ZERO_ADDR)) pending_d[issue_rd_i] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  // Per-port busy lookup.
  always_comb begin
    busy_c      = '0;
    lookup_addr = '0;
    for (int k = 0; k < NUM_READ; k++) begin
      lookup_addr = ad_i[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      busy_c[k]   = pending_q[lookup_addr];
`ifdef REGFILE_BYPASS_EN
      if (we_i && (wa_i == lookup_addr))
        busy_c[k] = issue_valid_i && (issue_rd_i == lookup_addr);
`endif
      if (lookup_addr == ZERO_ADDR) busy_c[k] = 1'b0;
    end
  end

endmodule

// File: rtl/pipelined_register_file.sv
// RV32 integer register file: NUM_READ combinational read ports, one write port,
// x0 hardwired to zero, pending-write hazard flags and a triggered a0 snapshot.
// Macro REGFILE_BYPASS_EN: forwards the in-flight write data to matching read ports.
// Ports:
//   clk, rst        clock, async active-high reset
//   AD_i / RD_o     packed read addresses / read data, port k at slice k
//   busy_o, stall_o per-port pending flag, OR of all ports
//   AD3_i/WE3_i/WD3_i  write address / enable / data
//   issue_valid_i, issue_rd_i  instruction issue marking a destination pending
//   trigger_i       level snapshot request, acted on at its rising edge
//   a0_o, a0_valid_o  registered snapshot of A0_INDEX, sticky snapshot-taken flag
module pipelined_register_file
  import regfile_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = REG_AW,
  parameter int unsigned DATA_WIDTH    = REG_DW,
  parameter int unsigned NUM_READ      = 2,
  parameter int unsigned A0_INDEX      = REG_A0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_READ*ADDRESS_WIDTH-1:0] AD_i,
  output logic [NUM_READ*DATA_WIDTH-1:0]    RD_o,
  output logic [NUM_READ-1:0]               busy_o,
  output logic                              stall_o,
  input  logic [ADDRESS_WIDTH-1:0]          AD3_i,
  input  logic                              WE3_i,
  input  logic [DATA_WIDTH-1:0]             WD3_i,
  input  logic                              issue_valid_i,
  input  logic [ADDRESS_WIDTH-1:0]          issue_rd_i,
  input  logic                              trigger_i,
  output logic [DATA_WIDTH-1:0]             a0_o,
  output logic                              a0_valid_o
);

  localparam int unsigned DEPTH = 2 ** ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] ZERO_ADDR = ADDRESS_WIDTH'(REG_ZERO);
  localparam logic [ADDRESS_WIDTH-1:0] A0_ADDR   = ADDRESS_WIDTH'(A0_INDEX);

  logic [DATA_WIDTH-1:0]    regs_q [DEPTH];
  logic [DATA_WIDTH-1:0]    regs_d [DEPTH];
  logic                     trigger_q, trigger_d;
  logic [DATA_WIDTH-1:0]    a0_q, a0_d;
  logic                     a0_valid_q, a0_valid_d;
  logic                     trigger_rise;
  logic [ADDRESS_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0]    rd_data;

  regfile_scoreboard #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .NUM_READ      (NUM_READ)
  ) u_scoreboard (
    .clk           (clk),
    .rst           (rst),
    .issue_valid_i (issue_valid_i),
    .issue_rd_i    (issue_rd_i),
    .we_i          (WE3_i),
    .wa_i          (AD3_i),
    .ad_i          (AD_i),
    .busy_c        (busy_o)
  );

  assign stall_o = |busy_o;

  // Storage next state; x0 is never written so it stays at its reset value of 0.
  always_comb begin
    regs_d = regs_q;
    if (WE3_i && (AD3_i != ZERO_ADDR)) regs_d[AD3_i] = WD3_i;
  end

  // Snapshot captures the post-write value of A0 so a same-cycle write is seen.
  always_comb begin
    trigger_rise = trigger_i && !trigger_q;
    trigger_d    = trigger_i;
    a0_d         = a0_q;
    a0_valid_d   = a0_valid_q;
    if (trigger_rise) begin
      a0_d       = regs_d[A0_ADDR];
      a0_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      trigger_q  <= 1'b0;
      a0_q       <= '0;
      a0_valid_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      trigger_q  <= trigger_d;
      a0_q       <= a0_d;
      a0_valid_q <= a0_valid_d;
    end
  end

  assign a0_o       = a0_q;
  assign a0_valid_o = a0_valid_q;

  // Zero-latency read muxes with optional write forwarding.
  always_comb begin
    RD_o    = '0;
    rd_addr = '0;
    rd_data = '0;
    for (int k = 0; k < NUM_READ; k++) begin
      rd_addr = AD_i[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      rd_data = regs_q[rd_addr];
`ifdef REGFILE_BYPASS_EN
      if (WE3_i && (AD3_i == rd_addr) && (rd_addr != ZERO_ADDR)) rd_data = WD3_i;
`endif
      RD_o[k*DATA_WIDTH +: DATA_WIDTH] = rd_data;
    end
  end

endmodule

// File: tb/tb_pipelined_register_file.sv
// Directed self-checking bench for pipelined_register_file (default 2 read ports).
module tb_pipelined_register_file;

  logic        clk;
  logic        rst;
  logic [9:0]  AD_i;
  logic [63:0] RD_o;
  logic [1:0]  busy_o;
  logic        stall_o;
  logic [4:0]  AD3_i;
  logic        WE3_i;
  logic [31:0] WD3_i;
  logic        issue_valid_i;
  logic [4:0]  issue_rd_i;
  logic        trigger_i;
  logic [31:0] a0_o;
  logic        a0_valid_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  pipelined_register_file dut (
    .clk           (clk),
    .rst           (rst),
    .AD_i          (AD_i),
    .RD_o          (RD_o),
    .busy_o        (busy_o),
    .stall_o       (stall_o),
    .AD3_i         (AD3_i),
    .WE3_i         (WE3_i),
    .WD3_i         (WD3_i),
    .issue_valid_i (issue_valid_i),
    .issue_rd_i    (issue_rd_i),
    .trigger_i     (trigger_i),
    .a0_o          (a0_o),
    .a0_valid_o    (a0_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    WE3_i = 1'b0; AD3_i = '0; WD3_i = '0;
    issue_valid_i = 1'b0; issue_rd_i = '0;
  endtask

  task automatic test_reset();
    logic [31:0] rd0, rd1;
    // Build up state: x5 written, x6 pending, x10 snapshotted.
    WE3_i = 1'b1; AD3_i = 5'd5; WD3_i = 32'h1111;
    issue_valid_i = 1'b1; issue_rd_i = 5'd6;
    tick();
    AD3_i = 5'd10; WD3_i = 32'd77; issue_valid_i = 1'b0; trigger_i = 1'b1;
    tick();
    idle(); trigger_i = 1'b0; AD_i = {5'd6, 5'd5};
    #1;
    total_cnt++;
    if (a0_o !== 32'd77 || a0_valid_o !== 1'b1)
      $display("FAIL pre_reset_a0: got %h/%b want 00000077/1", a0_o, a0_valid_o);
    else pass_cnt++;
    total_cnt++;
    if (busy_o !== 2'b10 || RD_o[31:0] !== 32'h1111)
      $display("FAIL pre_reset_state: busy %b rd0 %h want 10/00001111", busy_o, RD_o[31:0]);
    else pass_cnt++;
    // Async reset pulse between edges.
    rst = 1'b1;
    #1;
    rd0 = RD_o[31:0]; rd1 = RD_o[63:32];
    total_cnt++;
    if (rd0 !== 32'h0 || rd1 !== 32'h0)
      $display("FAIL reset_rd: got %h %h want 0 0", rd0, rd1);
    else pass_cnt++;
    total_cnt++;
    if (busy_o !== 2'b00) $display("FAIL reset_busy: got %b want 00", busy_o);
    else pass_cnt++;
    total_cnt++;
    if (stall_o !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall_o);
    else pass_cnt++;
    total_cnt++;
    if (a0_o !== 32'h0) $display("FAIL reset_a0: got %h want 0", a0_o);
    else pass_cnt++;
    total_cnt++;
    if (a0_valid_o !== 1'b0) $display("FAIL reset_a0_valid: got %b want 0", a0_valid_o);
    else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_x0();
    tick();
    WE3_i = 1'b1; AD3_i = 5'd0; WD3_i = 32'hDEADBEEF;
    issue_valid_i = 1'b1; issue_rd_i = 5'd0;
    AD_i = {5'd0, 5'd0};
    tick();
    idle();
    #1;
    total_cnt++;
    if (RD_o !== 64'h0) $display("FAIL x0_rd: got %h want 0", RD_o);
    else pass_cnt++;
    total_cnt++;
    if (busy_o !== 2'b00) $display("FAIL x0_busy: got %b want 00", busy_o);
    else pass_cnt++;
    total_cnt++;
    if (stall_o !== 1'b0) $display("FAIL x0_stall: got %b want 0", stall_o);
    else pass_cnt++;
  endtask

  task automatic test_scoreboard();
    issue_valid_i = 1'b1; issue_rd_i = 5'd5;
    tick();
    idle(); AD_i = {5'd0, 5'd5};
    #1;
    total_cnt++;
    if (busy_o !== 2'b01 || stall_o !== 1'b1)
      $display("FAIL sb_issue: busy %b stall %b want 01/1", busy_o, stall_o);
    else pass_cnt++;
    // Write cycle for x5.
    WE3_i = 1'b1; AD3_i = 5'd5; WD3_i = 32'h1234;
    #1;
`ifdef REGFILE_BYPASS_EN
    total_cnt++;
    if (busy_o !== 2'b00 || RD_o[31:0] !== 32'h1234)
      $display("FAIL sb_write_cycle: busy %b rd %h want 00/00001234", busy_o, RD_o[31:0]);
    else pass_cnt++;
`else
    total_cnt++;
    if (busy_o !== 2'b01 || RD_o[31:0] !== 32'h0)
      $display("FAIL sb_write_cycle: busy %b rd %h want 01/00000000", busy_o, RD_o[31:0]);
    else pass_cnt++;
`endif
    tick();
    idle();
    #1;
    total_cnt++;
    if (busy_o !== 2'b00 || stall_o !== 1'b0)
      $display("FAIL sb_clear: busy %b stall %b want 00/0", busy_o, stall_o);
    else pass_cnt++;
    total_cnt++;
    if (RD_o[31:0] !== 32'h1234) $display("FAIL sb_data: got %h want 00001234", RD_o[31:0]);
    else pass_cnt++;
  endtask

  task automatic test_same_cycle();
    WE3_i = 1'b1; AD3_i = 5'd7; WD3_i = 32'hAA;
    issue_valid_i = 1'b1; issue_rd_i = 5'd7;
    tick();
    idle(); AD_i = {5'd7, 5'd5};
    #1;
    total_cnt++;
    if (RD_o[63:32] !== 32'hAA) $display("FAIL same_data: got %h want 000000aa", RD_o[63:32]);
    else pass_cnt++;
    total_cnt++;
    if (busy_o !== 2'b10 || stall_o !== 1'b1)
      $display("FAIL same_busy: busy %b stall %b want 10/1", busy_o, stall_o);
    else pass_cnt++;
  endtask

  task automatic test_bypass();
    WE3_i = 1'b1; AD3_i = 5'd3; WD3_i = 32'h11;
    tick();
    AD_i = {5'd0, 5'd3}; WD3_i = 32'h55;
    #1;
`ifdef REGFILE_BYPASS_EN
    total_cnt++;
    if (RD_o[31:0] !== 32'h55) $display("FAIL bypass_same: got %h want 00000055", RD_o[31:0]);
    else pass_cnt++;
`else
    total_cnt++;
    if (RD_o[31:0] !== 32'h11) $display("FAIL bypass_same: got %h want 00000011", RD_o[31:0]);
    else pass_cnt++;
`endif
    tick();
    idle();
    #1;
    total_cnt++;
    if (RD_o[31:0] !== 32'h55) $display("FAIL bypass_after: got %h want 00000055", RD_o[31:0]);
    else pass_cnt++;
  endtask

  task automatic test_snapshot();
    WE3_i = 1'b1; AD3_i = 5'd10; WD3_i = 32'hCAFE; trigger_i = 1'b1;
    tick();
    idle();
    #1;
    total_cnt++;
    if (a0_o !== 32'hCAFE || a0_valid_o !== 1'b1)
      $display("FAIL snap_capture: got %h/%b want 0000cafe/1", a0_o, a0_valid_o);
    else pass_cnt++;
    // Trigger held: a further write must not be captured.
    WE3_i = 1'b1; AD3_i = 5'd10; WD3_i = 32'h1;
    tick();
    idle(); AD_i = {5'd0, 5'd10};
    tick();
    total_cnt++;
    if (a0_o !== 32'hCAFE) $display("FAIL snap_hold: got %h want 0000cafe", a0_o);
    else pass_cnt++;
    total_cnt++;
    if (RD_o[31:0] !== 32'h1) $display("FAIL snap_reg: got %h want 00000001", RD_o[31:0]);
    else pass_cnt++;
    // Release and re-raise: new capture of current x10.
    trigger_i = 1'b0;
    tick();
    total_cnt++;
    if (a0_o !== 32'hCAFE || a0_valid_o !== 1'b1)
      $display("FAIL snap_release: got %h/%b want 0000cafe/1", a0_o, a0_valid_o);
    else pass_cnt++;
    trigger_i = 1'b1;
    tick();
    total_cnt++;
    if (a0_o !== 32'h1) $display("FAIL snap_retrigger: got %h want 00000001", a0_o);
    else pass_cnt++;
    trigger_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; AD_i = '0; trigger_i = 1'b0;
    idle();
    #12;
    rst = 1'b0;
    tick();
    test_reset();
    test_x0();
    test_scoreboard();
    test_same_cycle();
    test_bypass();
    test_snapshot();
    tick();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
